// File: rtl/multi_vending_machine.sv
// Multi-product vending machine: edge-detected coin collection, lowest-index product
// selection, one-cycle vend and change-return states. Optional macro: MULTI_VEND_EN.
module multi_vending_machine #(
    parameter int                                NUM_PRODUCTS = 4,
    parameter int                                CREDIT_W     = 9,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0]  PRICES       = {9'd125, 9'd75, 9'd100, 9'd50},
    parameter int                                MAX_CREDIT   = 300
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [2:0]              coins,
    input  logic [NUM_PRODUCTS-1:0] sel,
    input  logic                    cancel,
    output logic [NUM_PRODUCTS-1:0] dispense,
    output logic [CREDIT_W-1:0]     change,
    output logic                    change_valid,
    output logic                    coin_reject,
    output logic [CREDIT_W-1:0]     credit,
    output logic [1:0]              state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        RETURN  = 2'd3
    } state_t;

    localparam int SUM_W = CREDIT_W + 1;

    state_t                  state_q, state_d;
    logic [CREDIT_W-1:0]     credit_q, credit_d;
    logic [NUM_PRODUCTS-1:0] dispense_q, dispense_d;
    logic [CREDIT_W-1:0]     change_q, change_d;
    logic                    changeValid_q, changeValid_d;
    logic                    coinReject_q, coinReject_d;
    logic [2:0]              coinPrev_q;
    logic [NUM_PRODUCTS-1:0] selPrev_q;

    logic                    coinEdge, selEdge, coinValid, coinFits, coinAccept;
    logic [CREDIT_W-1:0]     coinValue, creditSum, selPrice;
    logic [SUM_W-1:0]        sumWide;
    logic [NUM_PRODUCTS-1:0] selOneHot;

    assign coinEdge = (coins != 3'b000) && (coinPrev_q == 3'b000);
    assign selEdge  = (sel != '0) && (selPrev_q == '0);
    assign sumWide  = {1'b0, credit_q} + {1'b0, coinValue};
    assign coinFits = (sumWide <= SUM_W'(MAX_CREDIT));

    always_comb begin
        coinValid = 1'b1;
        coinValue = '0;
        case (coins)
            3'b001:  coinValue = CREDIT_W'(5);
            3'b010:  coinValue = CREDIT_W'(10);
            3'b011:  coinValue = CREDIT_W'(25);
            3'b100:  coinValue = CREDIT_W'(50);
            3'b101:  coinValue = CREDIT_W'(100);
            default: coinValid = 1'b0;
        endcase
    end

    // Scanning downward leaves the lowest set select bit as the winner.
    always_comb begin
        selOneHot = '0;
        selPrice  = '0;
        for (int k = NUM_PRODUCTS - 1; k >= 0; k--) begin
            if (sel[k]) begin
                selOneHot    = '0;
                selOneHot[k] = 1'b1;
                selPrice     = PRICES[k*CREDIT_W +: CREDIT_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        dispense_d    = '0;
        change_d      = '0;
        changeValid_d = 1'b0;
        coinReject_d  = 1'b0;
        coinAccept    = 1'b0;
        creditSum     = credit_q;
        case (state_q)
            IDLE, COLLECT: begin
                if (coinEdge) begin
                    if (coinValid && coinFits) coinAccept = 1'b1;
                    else                       coinReject_d = 1'b1;
                end
                if (coinAccept) creditSum = sumWide[CREDIT_W-1:0];
                if (state_q == IDLE) begin
                    credit_d = creditSum;
                    if (coinAccept) state_d = COLLECT;
                end else if (cancel) begin
                    state_d       = RETURN;
                    change_d      = creditSum;
                    changeValid_d = 1'b1;
                    credit_d      = '0;
                end else if (selEdge && (credit_q >= selPrice)) begin
                    state_d    = VEND;
                    dispense_d = selOneHot;
                    credit_d   = creditSum - selPrice;
                end else begin
                    credit_d = creditSum;
                end
            end
            VEND: begin
                coinReject_d = coinEdge;
                if (credit_q == '0) begin
                    state_d = IDLE;
                end else begin
`ifdef MULTI_VEND_EN
                    state_d = COLLECT;
`else
                    state_d       = RETURN;
                    change_d      = credit_q;
                    changeValid_d = 1'b1;
                    credit_d      = '0;
`endif
                end
            end
            RETURN: begin
                coinReject_d = coinEdge;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Edge history always tracks the raw inputs so held codes count only once.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            dispense_q    <= '0;
            change_q      <= '0;
            changeValid_q <= 1'b0;
            coinReject_q  <= 1'b0;
            coinPrev_q    <= 3'b000;
            selPrev_q     <= '0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            dispense_q    <= dispense_d;
            change_q      <= change_d;
            changeValid_q <= changeValid_d;
            coinReject_q  <= coinReject_d;
            coinPrev_q    <= coins;
            selPrev_q     <= sel;
        end
    end

    assign dispense     = dispense_q;
    assign change       = change_q;
    assign change_valid = changeValid_q;
    assign coin_reject  = coinReject_q;
    assign credit       = credit_q;
    assign state        = state_q;

endmodule

// File: doc/multi_vending_machine.md
MULTI_VENDING_MACHINE -- requirements
Module: multi_vending_machine

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- NUM_PRODUCTS, 4, number of selectable products.
- CREDIT_W, 9, width of credit, price and change values, in cents.
- PRICES, {125,75,100,50} packed CREDIT_W each, product i price at bits [i*CREDIT_W +: CREDIT_W]; each price nonzero and <= MAX_CREDIT.
- MAX_CREDIT, 300, maximum credit held, in cents.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clock, in, 1, single clock, rising edge.
- reset, in, 1, synchronous, active-high.
- coins, in, 3, coin code: 000 none, 001 nickel 5, 010 dime 10, 011 quarter 25, 100 half dollar 50, 101 dollar 100; 110/111 invalid.
- sel, in, NUM_PRODUCTS, product select, level.
- cancel, in, 1, request credit return.
- dispense, out, NUM_PRODUCTS, one-cycle pulse per vended product.
- change, out, CREDIT_W, change amount, valid with change_valid.
- change_valid, out, 1, one-cycle pulse.
- coin_reject, out, 1, one-cycle pulse, coin refused.
- credit, out, CREDIT_W, current credit.
- state, out, 2, FSM state: IDLE=0, COLLECT=1, VEND=2, RETURN=3.
REQ-003 All outputs SHALL be registered.

Function
REQ-004 A coin SHALL be accepted only on the first cycle coins is non-zero after a cycle sampled as 000; a held code counts once.
REQ-005 On acceptance, credit SHALL increase by the coin value on the next edge; visible one cycle after first sample.
REQ-006 A coin that would push credit above MAX_CREDIT, or an invalid code, SHALL raise coin_reject for one cycle and leave credit unchanged.
REQ-007 Coin edges SHALL be accepted in IDLE and COLLECT; coins seen in VEND or RETURN SHALL be rejected (coin_reject).
REQ-008 IDLE: credit == 0; an accepted coin SHALL move to COLLECT; sel and cancel ignored.
REQ-009 COLLECT: cancel SHALL move to RETURN; cancel overrides sel in the same cycle.
REQ-010 COLLECT: sel SHALL pick the lowest set bit i; if credit >= price i, move to VEND, else ignored (credit and state unchanged).
REQ-011 A coin accepted in the same cycle as a granted sel SHALL be added; credit_next = credit + coin - price.
REQ-012 VEND (exactly one cycle): dispense[i] SHALL pulse; next state is IDLE if remaining credit == 0, else per REQ-018.
REQ-013 RETURN (exactly one cycle): change = credit, change_valid pulse, credit cleared, next state IDLE.
REQ-014 change SHALL be 0 whenever change_valid is low; change_valid SHALL never pulse with change 0.
REQ-015 sel must return to 0 before a new selection is honoured (sel edge-detected like coins).

Reset
REQ-016 On reset, state=IDLE, credit=0, dispense=0, change=0, change_valid=0, coin_reject=0, and the coin/sel edge history SHALL be cleared to "none".
REQ-017 Reset mid-operation SHALL discard credit without a change_valid pulse; reset wins over all inputs.

Configuration
REQ-018 Macro MULTI_VEND_EN: defined, VEND with remaining credit > 0 SHALL return to COLLECT, keeping credit for further purchases; undefined, it SHALL go to RETURN and pay out the remaining credit.

Verification
REQ-019 The bench SHALL cover these directed scenarios with default parameters:
- DOLLAR held 3 cycles, then sel=0010 -> credit 100 (not 300), dispense[1] pulse, no change_valid, back to IDLE.
- DOLLAR, QUARTER, sel=0001 -> dispense[0], change_valid with change 75 (macro off).
- NICKEL, NICKEL, sel=0010 -> no dispense, credit 10; cancel -> change 10, IDLE.
- DOLLAR x3, HALFDOLLAR -> coin_reject pulse, credit stays 300; coins=111 -> coin_reject.
- DOLLAR, DOLLAR, sel=0001 -> macro on: credit 150, COLLECT; sel=0010 -> credit 50. Macro off: change 150 after first vend.
- DIME x4, reset in COLLECT -> credit 0, IDLE, no change_valid; sel=1111 with credit 125 -> dispense[0] only.
